// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake and instruction register feeding the decoder.
// Optional macro IFETCH_ALIGN_CHECK_EN adds a sticky misalign flag for unaligned redirect targets.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        imem_err
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_next_s;
    logic        req_s;
    logic        ack_take_s;
    logic        consume_s;
    logic [31:0] target_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign imem_req  = req_s;
    assign imem_addr = pc_r;

    // Handshake qualifiers: the request drops while a held instruction blocks the IR.
    always_comb begin
        req_s = 1'b0;
        if ((state_r == S_REQ) && !(ir_valid && stall)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        ack_take_s  = req_s & imem_ack;
        consume_s   = ir_valid & ~stall;
        wait_next_s = wait_cnt_r + 8'd1;
        target_s    = word_align(redirect_pc);
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (redirect_valid) begin
            if (req_s) begin
                state_s = S_FLUSH;
            end else begin
                state_s = S_REQ;
            end
        end else begin
            case (state_r)
                S_IDLE:  state_s = S_REQ;
                S_REQ: begin
                    if (ack_take_s && stall) begin
                        state_s = S_FULL;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        state_s = S_REQ;
                    end else begin
                        state_s = S_FULL;
                    end
                end
                S_FLUSH: state_s = S_REQ;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // PC, instruction register, wait counter and timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            ir_out     <= 32'h0000_0000;
            ir_valid   <= 1'b0;
            pc_out     <= 32'h0000_0000;
            pc_plus4   <= 32'h0000_0004;
            wait_cnt_r <= 8'd0;
            imem_err   <= 1'b0;
        end else if (redirect_valid) begin
            // Any ack arriving alongside the redirect belongs to the abandoned path.
            pc_r       <= target_s;
            ir_valid   <= 1'b0;
            wait_cnt_r <= 8'd0;
        end else if (ack_take_s) begin
            ir_out     <= imem_rdata;
            ir_valid   <= 1'b1;
            pc_out     <= pc_r;
            pc_plus4   <= pc_r + 32'd4;
            pc_r       <= pc_r + 32'd4;
            wait_cnt_r <= 8'd0;
        end else begin
            if (consume_s) begin
                ir_valid <= 1'b0;
            end
            // Counter saturates at TIMEOUT; the request stays up after the error.
            if (req_s && (wait_cnt_r != TIMEOUT_C)) begin
                wait_cnt_r <= wait_next_s;
                if (wait_next_s == TIMEOUT_C) begin
                    imem_err <= 1'b1;
                end
            end
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky flag for a redirect target that is not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: accepted fetches are queued and matched against the IR.
// Build with +define+IFETCH_ALIGN_CHECK_EN to also check the misalign flag.
module tb_ifetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        imem_err;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    fetch_t      sb_q[$];
    logic [31:0] model_pc;
    int          n_cmp;
    int          n_bad;

    ifetch_stage #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_out         (ir_out),
        .ir_valid       (ir_valid),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .imem_err       (imem_err)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, offer an ack if wanted, clock, then score the result.
    task automatic step(input logic st, input logic rv, input logic [31:0] rp,
                        input logic ack_en, input logic [31:0] data, input logic exp_req);
        logic   took;
        fetch_t f;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        check_val("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) begin
            check_val("imem_addr", imem_addr, model_pc);
        end
        took = imem_req && ack_en;
        if (took) begin
            imem_ack   = 1'b1;
            imem_rdata = data;
        end
        @(posedge clk);
        #1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0000_0000;
        redirect_valid = 1'b0;
        if (rv) begin
            model_pc = {rp[31:2], 2'b00};
        end else if (took) begin
            sb_q.push_back({model_pc, data});
            model_pc = model_pc + 32'd4;
        end
        if (sb_q.size() > 0) begin
            f = sb_q.pop_front();
            check_val("ir_out", ir_out, f.data);
            check_val("pc_out", pc_out, f.pc);
            check_val("pc_plus4", pc_plus4, f.pc + 32'd4);
            check_val("ir_valid", {31'd0, ir_valid}, 32'd1);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0000_0000;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        model_pc       = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check_val("rst_ir_out", ir_out, 32'h0000_0000);
        check_val("rst_pc_out", pc_out, 32'h0000_0000);
        check_val("rst_pc_plus4", pc_plus4, 32'h0000_0004);
        check_val("rst_err", {31'd0, imem_err}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h0000_0000);
`ifdef IFETCH_ALIGN_CHECK_EN
        check_val("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
        rst_n = 1'b1;

        // Idle cycle, then back-to-back zero-wait fetches.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0820, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2002_000a, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2403_000a, 1'b1);

        // Stall with a live instruction: request drops and the IR freezes.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0043_2021, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000, 1'b0);
            check_val("hold_ir", ir_out, 32'h0043_2021);
            check_val("hold_pc", pc_out, 32'h0000_000C);
            check_val("hold_valid", {31'd0, ir_valid}, 32'd1);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8c22_0004, 1'b1);

        // Redirect with a concurrent ack: data dropped, one-cycle flush.
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check_val("redir_valid", {31'd0, ir_valid}, 32'd0);
        check_val("redir_ir_kept", ir_out, 32'h8c22_0004);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_val("flush_addr", imem_addr, 32'h0000_0040);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2042_0001, 1'b1);

        // Memory never answers: error on the 16th waiting cycle, then sticky.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check_val("timeout_err", {31'd0, imem_err}, {31'd0, (i >= 15)});
        end
        check_val("timeout_valid", {31'd0, ir_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0044_2824, 1'b1);
        check_val("late_err", {31'd0, imem_err}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        check_val("full_ir", ir_out, 32'h0044_2824);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        check_val("full_consumed", {31'd0, ir_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h3c01_1001, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
        check_val("wrap_plus4", pc_plus4, 32'h0000_0000);
        check_val("wrap_addr", imem_addr, 32'h0000_0000);

        // Unaligned redirect target: low bits dropped.
        step(1'b0, 1'b1, 32'h0000_0046, 1'b0, 32'h0, 1'b1);
`ifdef IFETCH_ALIGN_CHECK_EN
        check_val("misalign", {31'd0, misalign}, 32'd1);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_val("align_addr", imem_addr, 32'h0000_0044);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2408_0001, 1'b1);

        // Asynchronous reset in the middle of a request.
        stall = 1'b0;
        #1;
        check_val("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check_val("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
        check_val("mid_rst_ir", ir_out, 32'h0000_0000);
        check_val("mid_rst_pc_out", pc_out, 32'h0000_0000);
        check_val("mid_rst_err", {31'd0, imem_err}, 32'd0);
        check_val("mid_rst_addr", imem_addr, 32'h0000_0000);
`ifdef IFETCH_ALIGN_CHECK_EN
        check_val("mid_rst_misalign", {31'd0, misalign}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_pc = 32'h0000_0000;
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA, 1'b0);
        check_val("post_rst_idle", {31'd0, ir_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0820, 1'b1);
        check_val("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
